// File: rtl/spi_rx_loader.sv
// Parses SPI load frames (opcode, address, word count, data words) from a byte stream
// and issues 32-bit word writes on a req/gnt memory port.
module spi_rx_loader #(
  parameter int unsigned FifoDepth = 8,
  parameter logic [7:0]  OpWrite   = 8'h02
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_push_i,
  input  logic        spi_cs_i,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        frame_done_o,
  output logic        frame_err_o,
  output logic        overflow_o
);

  localparam int unsigned AW = $clog2(FifoDepth);
  localparam logic [AW:0] FullCount = (AW+1)'(FifoDepth);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LEN,
    S_DATA,
    S_REQ
  } state_t;

  state_t        r_state;
  logic [7:0]    r_mem [FifoDepth];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          r_overflow;
  logic [1:0]    r_byte_cnt;
  logic [7:0]    r_word_cnt;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic          r_req;
  logic          r_done;
  logic          r_err;

  logic          w_empty;
  logic          w_full;
  logic          w_flush;
  logic          w_pop;
  logic          w_push_ok;
  logic          w_xfer;
  logic [7:0]    w_head;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == FullCount);
  assign w_xfer    = r_req & mem_gnt_i;
  // A pending write is never retracted: in REQ the flush waits for the grant.
  assign w_flush   = spi_cs_i & ((r_state != S_REQ) | mem_gnt_i);
  assign w_pop     = ~w_empty & ~spi_cs_i & (r_state != S_REQ);
  assign w_push_ok = rx_push_i & (~w_full | w_pop) & ~w_flush;
  assign w_head    = r_mem[r_rptr];

  always_ff @(posedge clk_i) begin
    if (w_push_ok) begin
      r_mem[r_wptr] <= rx_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (w_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      r_count <= r_count + {{AW{1'b0}}, w_push_ok} - {{AW{1'b0}}, w_pop};
      if (rx_push_i & w_full & ~w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_byte_cnt <= '0;
      r_word_cnt <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_req      <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            if (w_head == OpWrite) begin
              r_state    <= S_ADDR;
              r_byte_cnt <= '0;
            end else if ((w_head != 8'h00) && (w_head != 8'hFF)) begin
              r_err <= 1'b1;
            end
          end
        end
        S_ADDR: begin
          if (w_flush) begin
            r_err      <= 1'b1;
            r_state    <= S_IDLE;
            r_byte_cnt <= '0;
          end else if (w_pop) begin
            r_addr     <= {r_addr[23:0], w_head};
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              r_state <= S_LEN;
            end
          end
        end
        S_LEN: begin
          if (w_flush) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else if (w_pop) begin
            if (w_head == 8'h00) begin
              r_err   <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_word_cnt <= w_head;
              r_byte_cnt <= '0;
              r_state    <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_flush) begin
            r_err      <= 1'b1;
            r_state    <= S_IDLE;
            r_byte_cnt <= '0;
          end else if (w_pop) begin
            r_wdata    <= {r_wdata[23:0], w_head};
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              r_req   <= 1'b1;
              r_state <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (w_xfer) begin
            r_req      <= 1'b0;
            r_addr     <= r_addr + 32'd4;
            r_word_cnt <= r_word_cnt - 8'd1;
            if (w_flush) begin
              r_err   <= 1'b1;
              r_state <= S_IDLE;
            end else if (r_word_cnt == 8'd1) begin
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_state <= S_DATA;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req_o    = r_req;
  assign mem_we_o     = r_req;
  assign mem_be_o     = {4{r_req}};
  assign mem_addr_o   = r_addr;
  assign mem_wdata_o  = r_wdata;
  assign frame_done_o = r_done;
  assign frame_err_o  = r_err;
  assign overflow_o   = r_overflow;

endmodule

// File: doc/spi_rx_loader.md
Name: spi_rx_loader

Overview:
- Sits directly downstream of the SPI receive-only slave. Consumes its byte stream (data + 1-cycle push strobe) through a small internal FIFO.
- Parses load frames from the stream and turns them into 32-bit word write requests on a req/gnt memory port.
- Used to load program or data memory from an external SPI master while the core is held off.

Parameters:
- FifoDepth, 8, byte FIFO entries; power of two, >= 2
- OpWrite, 8'h02, opcode byte that starts a write frame

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- rx_data_i  in  8  received byte from SPI slave
- rx_push_i  in  1  1-cycle strobe; rx_data_i valid this cycle
- spi_cs_i  in  1  SPI chip select, active-low, already synchronized to clk_i
- mem_req_o  out  1  write request
- mem_gnt_i  in  1  grant; transfer completes in a cycle where req & gnt
- mem_we_o  out  1  always 1 while mem_req_o is high, else 0
- mem_be_o  out  4  always 4'hF while mem_req_o is high, else 0
- mem_addr_o  out  32  word address
- mem_wdata_o  out  32  word data
- frame_done_o  out  1  1-cycle pulse: frame fully written
- frame_err_o  out  1  1-cycle pulse: bad opcode, zero length, or abort
- overflow_o  out  1  sticky: a byte was dropped on a full FIFO

Behaviour:
- Reset (rst_i high at a clk_i edge):
  - all outputs 0; FIFO empty; FSM in IDLE; counters 0.
  - Reset overrides any pending request.
- FIFO:
  - Push on rx_push_i when not full.
  - Push on full: byte is dropped and overflow_o is set until reset, except a same-cycle pop makes room and the push is accepted.
  - Push and pop in the same cycle keep the count unchanged.
  - A byte pushed into an empty FIFO is visible to the parser the next cycle.
  - At most one pop per cycle.
- Frame format, in byte order:
  - opcode
  - addr[31:24], addr[23:16], addr[15:8], addr[7:0]
  - len: word count, 1..255
  - len words of 4 bytes each, MSB first
- FSM states: IDLE, ADDR, LEN, DATA, REQ.
- IDLE:
  - Pop a byte when FIFO is non-empty.
  - OpWrite -> ADDR with byte counter 0.
  - 8'h00 or 8'hFF: discarded silently (bus fill), stay IDLE.
  - Any other value: frame_err_o pulse next cycle, stay IDLE.
- ADDR: pop 4 bytes, shift into the address register MSB first -> LEN.
- LEN:
  - Pop 1 byte.
  - 0: frame_err_o pulse -> IDLE.
  - Otherwise load the word counter -> DATA.
- DATA: pop 4 bytes into the wdata shift register. The cycle after the 4th pop, mem_req_o = 1 -> REQ.
- REQ:
  - Hold mem_req_o, mem_addr_o and mem_wdata_o stable until mem_gnt_i.
  - No pops in REQ.
  - On gnt: address += 4 (32-bit wrap, no error); word counter -= 1; mem_req_o drops next cycle.
  - If the counter reaches 0: frame_done_o pulses the cycle after gnt -> IDLE. Otherwise -> DATA.
- Minimum throughput: 5 cycles per word when the FIFO is kept fed and gnt is immediate.
- Abort:
  - Triggered by spi_cs_i == 1 while the state is ADDR, LEN or DATA, or on the cycle REQ completes.
  - The FSM goes to IDLE and the FIFO is flushed.
  - frame_err_o pulses once.
  - A request already in REQ is never retracted. It completes, then the abort is taken, with no frame_done_o.
  - spi_cs_i high in IDLE: FIFO is flushed, no error.
- Simultaneous abort and FIFO push: the flush wins and the byte is dropped. overflow_o is not set.
- frame_done_o and frame_err_o are never high in the same cycle.

Test Plan:
- Frame with 1 word:
  - Stimulus: push bytes 02 00 00 10 00 01 DE AD BE EF, gnt tied 1.
  - Required: exactly one req with addr 32'h0000_1000, wdata 32'hDEADBEEF, be F, we 1; frame_done_o one pulse; no error.
- Frame with 3 words:
  - Stimulus: 02 FF FF FF FC 03 then 12 data bytes; gnt delayed 3 cycles per request.
  - Required: addresses FFFF_FFFC, 0000_0000, 0000_0004 (wrap); addr and data stable while req waits.
- Invalid frames:
  - Stimulus: opcode 7E, then 02 00 00 00 00 00.
  - Required: frame_err_o pulses twice; zero requests; bytes 00 and FF fed alone produce no error.
- Overflow:
  - Stimulus: FifoDepth=8; hold gnt 0 during a 2-word frame; push 12 further bytes back-to-back.
  - Required: overflow_o rises at the first dropped byte and stays high until reset.
- Abort:
  - Stimulus: raise spi_cs_i after 02 00 00 → FSM in ADDR.
  - Required: frame_err_o pulse, FIFO empty, no req.
  - Stimulus: repeat with cs raised while in REQ with gnt 0.
  - Required: req held until gnt, one transfer completes, then err pulse, no done.
- Reset mid-frame:
  - Stimulus: assert rst_i during REQ with gnt 0.
  - Required: next cycle mem_req_o = 0, FIFO empty, FSM IDLE; a subsequent full frame completes normally.
